// File: rtl/mem_arbiter_if.sv
// Request/RAM bus bundle for mem_arbiter.
// slave  : the arbiter's view (takes requests and RAM status, drives hits and RAM strobes).
// master : the surrounding datapath + RAM view.
interface mem_arbiter_if;
    // request side
    logic        iREN;
    logic [31:0] iaddr;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic        ihit;
    logic        dhit;
    logic [31:0] iload;
    logic [31:0] dload;
    // ram side
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    logic [1:0]  ramstate;
    // status
    logic        err;
    logic        busy;

    modport slave (
        input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        output ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err, busy
    );

    modport master (
        output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
        input  ihit, dhit, iload, dload, ramREN, ramWEN, ramaddr, ramstore, err, busy
    );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: serialises fetch and data requests onto one RAM
// port. Data wins ties unless the previous completed grant was data and a fetch
// is waiting, which makes continuous contention alternate D, I, D, I.
// A grant ends on ACCESS (hit), request withdrawal, RAM ERROR or watchdog timeout.
module mem_arbiter #(
    parameter int TIMEOUT = 64,   // >= 2
    parameter int CNT_W   = 7     // must hold TIMEOUT
) (
    input  logic         CLK,
    input  logic         RST,
    mem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, DGRANT = 2'd1, IGRANT = 2'd2} state_t;

    localparam logic [1:0] RAM_ACCESS = 2'd2;
    localparam logic [1:0] RAM_ERROR  = 2'd3;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             last_d_q, last_d_d;
    logic             err_q, err_d;

    logic dreq, in_d, in_i, req_live, access, ram_err, timeout, hit;

    // Grant decision and grant termination; strobes and hits depend on the
    // live request so a flush drops them in the same cycle.
    always_comb begin
        dreq     = bus.dREN | bus.dWEN;
        in_d     = (state_q == DGRANT);
        in_i     = (state_q == IGRANT);
        req_live = in_d ? dreq : (in_i ? bus.iREN : 1'b0);
        access   = (bus.ramstate == RAM_ACCESS);
        ram_err  = (bus.ramstate == RAM_ERROR);
        timeout  = (wcnt_q == CNT_W'(TIMEOUT - 1));
        hit      = req_live & access;

        state_d  = state_q;
        wcnt_d   = wcnt_q;
        last_d_d = last_d_q;
        err_d    = err_q;

        case (state_q)
            IDLE: begin
                if (dreq && !(bus.iREN && last_d_q)) begin
                    state_d = DGRANT;
                    wcnt_d  = '0;
                end else if (bus.iREN) begin
                    state_d = IGRANT;
                    wcnt_d  = '0;
                end
            end
            DGRANT, IGRANT: begin
                if (!req_live) begin
                    // withdrawal beats a same-cycle ACCESS; fairness untouched
                    state_d = IDLE;
                end else if (access) begin
                    state_d  = IDLE;
                    last_d_d = in_d;
                end else if (ram_err || timeout) begin
                    // requester keeps its line up and is re-arbitrated
                    state_d = IDLE;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State, watchdog, fairness bit and sticky error; reset wins over everything.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            wcnt_q   <= '0;
            last_d_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            wcnt_q   <= wcnt_d;
            last_d_q <= last_d_d;
            err_q    <= err_d;
        end
    end

    assign bus.dhit     = in_d & hit;
    assign bus.ihit     = in_i & hit;
    assign bus.dload    = (in_d & hit) ? bus.ramload : 32'h0;
    assign bus.iload    = (in_i & hit) ? bus.ramload : 32'h0;
    assign bus.ramREN   = in_d ? bus.dREN : (in_i ? bus.iREN : 1'b0);
    assign bus.ramWEN   = in_d & bus.dWEN;
    assign bus.ramaddr  = in_d ? bus.daddr : (in_i ? bus.iaddr : 32'h0);
    assign bus.ramstore = in_d ? bus.dstore : 32'h0;
    assign bus.err      = err_q;
    assign bus.busy     = (state_q != IDLE);
endmodule

// File: tb/tb_mem_arbiter.sv
// Randomised bench for mem_arbiter. A RAM model answers each access after a
// random latency (sometimes ERROR, sometimes never -> watchdog). Expected hits
// are queued by the RAM model from the arbitration rules; a separate monitor
// pops them when the DUT raises ihit/dhit.
module tb_mem_arbiter;
    localparam int TO = 4;
    localparam logic [1:0] FREE = 2'd0, BUSY = 2'd1, ACCESS = 2'd2, ERROR = 2'd3;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    mem_arbiter_if bus();

    mem_arbiter #(.TIMEOUT(TO), .CNT_W(7)) dut (.CLK(CLK), .RST(RST), .bus(bus));

    always #5 CLK = ~CLK;

    typedef struct { bit is_d; logic [31:0] load; } exp_t;
    exp_t sb[$];

    int vectors = 0;
    int miscompares = 0;

    // model / control state
    bit en_model = 0, en_mon = 0;
    bit last_d_m, err_exp, err_pend, expect_drop, prev_strobe;
    bit snap_d, snap_i, strobe, use_err;
    int owner, scnt, lat;
    logic [31:0] rdata;
    int ihit_cnt = 0, dhit_cnt = 0;

    // requester state (driver only)
    bit dpend = 0, ipend = 0;
    int dcool = 0, icool = 0, ihit_used = 0, dhit_used = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // RAM model + reference: predicts the grant owner from the rules, checks
    // the RAM bus, picks the response and queues the expected hit.
    always @(posedge CLK) begin
        snap_d = bus.dREN | bus.dWEN;
        snap_i = bus.iREN;
        if (err_pend) begin err_exp = 1'b1; err_pend = 1'b0; end
        #2;
        if (!en_model) begin
            bus.ramstate = FREE; bus.ramload = 32'h0;
            last_d_m = 0; err_exp = 0; err_pend = 0; expect_drop = 0;
            prev_strobe = 0; owner = 0; scnt = 0;
        end else begin
            strobe = bus.ramREN | bus.ramWEN;
            if (expect_drop) begin
                check("grant_end_drop", 128'(strobe), 128'(0));
                expect_drop = 0;
            end
            if (strobe && !prev_strobe) begin
                if (snap_d && !(snap_i && last_d_m)) owner = 1;
                else if (snap_i) owner = 2;
                else begin owner = 0; check("grant_spurious", 128'(strobe), 128'(0)); end
                scnt = 0;
                lat = $urandom_range(0, 5);
                use_err = ($urandom_range(0, 9) == 0);
                rdata = $urandom;
            end
            if (strobe && owner != 0) begin
                if (owner == 1)
                    check("ram_bus_d", 128'({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}),
                          128'({bus.dREN, bus.dWEN, bus.daddr, bus.dstore}));
                else
                    check("ram_bus_i", 128'({bus.ramREN, bus.ramWEN, bus.ramaddr, bus.ramstore}),
                          128'({1'b1, 1'b0, bus.iaddr, 32'h0}));
                check("busy_granted", 128'(bus.busy), 128'(1));
                if (scnt == lat) begin
                    expect_drop = 1;
                    if (use_err) begin
                        bus.ramstate = ERROR; bus.ramload = $urandom;
                        err_pend = 1;
                    end else begin
                        bus.ramstate = ACCESS; bus.ramload = rdata;
                        sb.push_back('{is_d: (owner == 1), load: rdata});
                        last_d_m = (owner == 1);
                    end
                end else begin
                    bus.ramstate = BUSY; bus.ramload = $urandom;
                    if (scnt == TO - 1) begin err_pend = 1; expect_drop = 1; end
                end
                scnt++;
            end else begin
                bus.ramstate = FREE; bus.ramload = $urandom;
            end
            prev_strobe = strobe;
        end
    end

    // Monitor: pops the scoreboard whenever a hit is presented.
    always @(negedge CLK) begin
        exp_t e;
        if (en_mon) begin
            check("hit_exclusive", 128'(bus.ihit & bus.dhit), 128'(0));
            if (!bus.ihit) check("iload_idle", 128'(bus.iload), 128'(0));
            if (!bus.dhit) check("dload_idle", 128'(bus.dload), 128'(0));
            if (bus.ihit) ihit_cnt++;
            if (bus.dhit) dhit_cnt++;
            if (bus.ihit || bus.dhit) begin
                if (sb.size() == 0) begin
                    vectors++; miscompares++;
                    $display("FAIL unexpected_hit: ihit=%b dhit=%b with no hit expected at %0t",
                             bus.ihit, bus.dhit, $time);
                end else begin
                    e = sb.pop_front();
                    check("hit_kind", 128'(bus.dhit), 128'(e.is_d));
                    check("hit_load", 128'(e.is_d ? bus.dload : bus.iload), 128'(e.load));
                end
            end
            while (sb.size() != 0) begin
                e = sb.pop_front();
                vectors++; miscompares++;
                $display("FAIL missing_hit: no hit observed, expected %s hit load %h at %0t",
                         e.is_d ? "data" : "fetch", e.load, $time);
            end
            check("err", 128'(bus.err), 128'(err_exp));
        end
    end

    // One cycle of requester behaviour: hold until hit, occasional flush.
    task automatic step(input bit allow_new);
        @(posedge CLK); #1;
        if (dpend) begin
            if (dhit_cnt != dhit_used) begin
                dhit_used = dhit_cnt; dpend = 0; bus.dREN = 0; bus.dWEN = 0;
            end else if ($urandom_range(0, 39) == 0) begin
                dpend = 0; bus.dREN = 0; bus.dWEN = 0; dcool = 2;
            end
        end else if (dcool > 0) dcool--;
        else if (allow_new && $urandom_range(0, 2) == 0) begin
            dpend = 1;
            if ($urandom_range(0, 1) == 1) bus.dREN = 1; else bus.dWEN = 1;
            bus.daddr = $urandom & 32'hFFFF_FFFC;
            bus.dstore = $urandom;
        end
        if (ipend) begin
            if (ihit_cnt != ihit_used) begin
                ihit_used = ihit_cnt; ipend = 0; bus.iREN = 0;
            end else if ($urandom_range(0, 39) == 0) begin
                ipend = 0; bus.iREN = 0; icool = 2;
            end
        end else if (icool > 0) icool--;
        else if (allow_new && $urandom_range(0, 2) == 0) begin
            ipend = 1; bus.iREN = 1;
            bus.iaddr = $urandom & 32'hFFFF_FFFC;
        end
    endtask

    task automatic run_phase(input int cycles);
        int n;
        repeat (cycles) step(1);
        n = 0;
        while ((dpend || ipend) && n < 300) begin step(0); n++; end
        check("drain_done", 128'({dpend, ipend}), 128'(0));
        repeat (3) step(0);
    endtask

    initial begin
        bus.iREN = 1; bus.iaddr = 32'h40;
        bus.dREN = 0; bus.dWEN = 0; bus.daddr = 0; bus.dstore = 0;
        // reset held over two edges with a fetch pending
        repeat (2) begin
            @(negedge CLK);
            check("reset_outs", 128'({bus.ihit, bus.dhit, bus.ramREN, bus.ramWEN, bus.busy, bus.err}), 128'(0));
            check("reset_bus", 128'({bus.ramaddr, bus.ramstore}), 128'(0));
        end
        RST = 0;
        @(negedge CLK);
        check("igrant_after_rst", 128'({bus.ramREN, bus.busy, bus.ramaddr}), 128'({2'b11, 32'h40}));
        // reset while granted: strobe drops, no hit
        RST = 1;
        @(negedge CLK);
        check("rst_mid_grant", 128'({bus.ihit, bus.ramREN, bus.busy}), 128'(0));
        RST = 0; bus.iREN = 0;
        en_model = 1; en_mon = 1;

        run_phase(1500);

        // reset clears the sticky error
        en_mon = 0; en_model = 0;
        @(posedge CLK); #1;
        RST = 1;
        @(posedge CLK); #1;
        @(negedge CLK);
        check("err_cleared", 128'({bus.err, bus.busy}), 128'(0));
        RST = 0;
        en_model = 1; en_mon = 1;

        run_phase(600);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Single-port memory arbiter and responder for the pipeline's instruction-fetch and data-access requests. Returns the ihit/dhit completion pulses that the hazard and stall logic consume.
- Serialises requests onto one RAM port. Data has priority, with a starvation guard for fetch. Each request completes on the RAM's ACCESS state.
- Watchdog timeout and a sticky error flag.
- Sits between the datapath (request side) and the RAM model/controller (ram side).

Parameters:
- TIMEOUT, 64: max cycles a granted request may wait for ACCESS before being aborted; must be >= 2.
- CNT_W, 7: width of the wait counter; must hold TIMEOUT.

Ports:
- CLK  in  1  system clock, rising edge
- RST  in  1  synchronous active-high reset
- iREN  in  1  instruction fetch request, held until ihit
- iaddr  in  32  fetch address
- dREN  in  1  data read request, held until dhit
- dWEN  in  1  data write request, held until dhit (never with dREN)
- daddr  in  32  data address
- dstore  in  32  write data
- ihit  out  1  fetch complete, 1-cycle pulse
- dhit  out  1  data access complete, 1-cycle pulse
- iload  out  32  fetched word, valid only while ihit
- dload  out  32  read word, valid only while dhit
- ramREN  out  1  RAM read strobe
- ramWEN  out  1  RAM write strobe
- ramaddr  out  32  RAM address
- ramstore  out  32  RAM write data
- ramload  in  32  RAM read data
- ramstate  in  2  RAM status: 0 FREE, 1 BUSY, 2 ACCESS, 3 ERROR
- err  out  1  sticky: timeout or RAM ERROR seen
- busy  out  1  1 when state != IDLE

Behaviour:
- States: IDLE, DGRANT, IGRANT.
- Registers: state, wait counter wcnt, fairness bit last_d (last completed grant was data), err.
- Reset (synchronous, wins over everything): state=IDLE, wcnt=0, last_d=0, err=0.
  - All outputs are 0 in the cycle after reset: ihit, dhit, ram strobes, ramaddr, ramstore, busy, err.
- Reset mid-grant: the RAM strobe drops next cycle and no hit is issued.
- IDLE: ram strobes 0, ramaddr=0, ramstore=0.
  - Grant decision uses dreq = dREN|dWEN.
  - dreq && !(iREN && last_d) -> DGRANT.
  - iREN && (!dreq || last_d) -> IGRANT.
  - Neither -> stay in IDLE.
  - wcnt cleared on every transition into a grant state.
- DGRANT drives: ramREN=dREN, ramWEN=dWEN, ramaddr=daddr, ramstore=dstore.
- IGRANT drives: ramREN=1, ramWEN=0, ramaddr=iaddr, ramstore=0.
- Completion in a grant state, same cycle as ramstate==ACCESS (combinational):
  - DGRANT: dhit=1, dload=ramload.
  - IGRANT: ihit=1, iload=ramload.
  - Next state IDLE; last_d updated (1 for data, 0 for fetch).
- Latency: a request first seen in IDLE at cycle N drives the RAM from cycle N+1. Minimum hit cycle is N+1, when RAM answers ACCESS immediately. Back-to-back requests incur one IDLE bubble.
- Request withdrawn while granted (the active request line deasserts, e.g. flush):
  - Return to IDLE next cycle, no hit, last_d unchanged.
  - RAM strobes follow the request combinationally, so they drop the same cycle.
- ramstate==ERROR while granted: err<=1, return to IDLE with no hit; the requester retries.
- Timeout:
  - wcnt increments each granted cycle without ACCESS.
  - When wcnt==TIMEOUT-1 and no ACCESS that cycle: err<=1, return to IDLE, no hit.
- ACCESS and withdrawal in the same cycle: the withdrawal wins, no hit.
- hit outputs are never both 1. A hit is only asserted in a grant state.
- err clears only on RST.
- iload/dload read 0 when the corresponding hit is 0.
- Fairness: when both requesters are pending continuously, grants alternate D, I, D, I... A lone requester is never blocked by last_d.

Test Plan:
- Reset: assert RST 2 cycles with iREN=1 -> ihit=0, ramREN=0, busy=0, err=0 during and 1 cycle after; IGRANT entered the following cycle.
- Single read: dREN=1, daddr=0x100, RAM BUSY 3 cycles then ACCESS with ramload=0xDEADBEEF -> ramREN=1, ramaddr=0x100 for 4 cycles; dhit=1 for exactly 1 cycle with dload=0xDEADBEEF.
- Write: dWEN=1, daddr=0x200, dstore=0x12345678, immediate ACCESS -> ramWEN=1, ramstore=0x12345678, dhit at cycle N+1, ramREN=0 throughout.
- Contention: iREN and dREN held, RAM ACCESS after 1 BUSY cycle each -> completion order dhit, ihit, dhit, ihit, with one IDLE bubble between grants; never both hits in the same cycle.
- Flush: iREN dropped 2 cycles into IGRANT while ramstate=BUSY -> ramREN=0 the same cycle, ihit never asserted, IDLE next cycle, err=0.
- Faults:
  - TIMEOUT=4, ramstate stuck BUSY -> grant aborts after 4 granted cycles, err=1 sticky until RST.
  - Separately, ramstate=ERROR -> err=1, no hit.
